// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditions a raw push-button or slide-switch pin into a clean,
// clock-synchronous level plus one-cycle press/release pulses.
//
//   pin -> two-flop synchroniser -> polarity normalisation -> debounce FSM
//
// The debounced level 'out' is 1 while the button is considered pressed.
// 'press' pulses in the cycle 'out' rises. 'release_pulse' pulses in the
// cycle 'out' falls. The release port cannot be called 'release' because
// that is a reserved word.
//
// A change is accepted only after DB_CYCLES consecutive samples of the new
// level. Any bounce back to the old level restarts the count, so a pulse
// shorter than DB_CYCLES samples never reaches 'out'.
//
// Optional feature (compile-time macro LONG_PRESS_EN):
//   When defined, the module has a 'long_press' output. It pulses exactly
//   once per press, LONG_CYCLES cycles after 'press'. Bounces that are
//   rejected while held do not restart the hold timer. When the macro is
//   undefined, the port and the hold counter are absent and the rest of
//   the behaviour is unchanged.
//
// Reset is synchronous and active-high. The synchroniser is reset to the
// inactive pin level, so the normalised button reads "not pressed" right
// after reset. A button held through reset is debounced again and then
// produces a fresh 'press'.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DB_CYCLES   = 1000000,  // stable samples to accept a change
  parameter bit          ACTIVE_LOW  = 1'b1,     // 1: pin reads 0 when pressed
  parameter int unsigned LONG_CYCLES = 50000000  // hold cycles before long_press
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic press,
  output logic release_pulse
`ifdef LONG_PRESS_EN
  ,
  output logic long_press
`endif
);

  // -------------------------------------------------------------------------
  // Derived sizes
  // -------------------------------------------------------------------------
  // The debounce counter only ever holds values 0 .. DB_CYCLES-1.
  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Pin level seen when the button is not pressed.
  localparam logic PIN_IDLE = ACTIVE_LOW;

  // Reject configurations the FSM cannot implement. With DB_CYCLES < 2 the
  // first stable sample would already be the last one, which the
  // IDLE -> CHK_ON handshake cannot express.
  if (DB_CYCLES < 2) begin : g_bad_db
    $error("button_debounce: DB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("button_debounce: LONG_CYCLES must be at least 2");
  end

  // -------------------------------------------------------------------------
  // Debounce states
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,  // released and stable
    S_CHK_ON  = 2'd1,  // released, counting pressed samples
    S_ON      = 2'd2,  // pressed and stable
    S_CHK_OFF = 2'd3   // pressed, counting released samples
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Synchroniser flops and the polarity-normalised button level.
  logic s1;
  logic s2;
  logic btn;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser for the asynchronous pin
  // -------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments (<=). All flops
  // then sample the values from before the edge, so s2 really lags s1 by one
  // cycle and no process can see a half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= PIN_IDLE;
      s2 <= PIN_IDLE;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  // 1 means pressed, whatever the pin polarity.
  assign btn = s2 ^ ACTIVE_LOW;

  // -------------------------------------------------------------------------
  // Debounce FSM with registered level and edge pulses
  // -------------------------------------------------------------------------
  // Each transition is paired with its counter update. In the checking
  // states, the sample that caused entry counts as the first stable sample,
  // so the counter starts at 1. The change is accepted when the counter
  // reaches DB_CYCLES-1 while the level still holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      out           <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // Pulses last one cycle unless a transition below sets them again.
      press         <= 1'b0;
      release_pulse <= 1'b0;

      case (state)
        S_IDLE: begin
          if (btn) begin
            state <= S_CHK_ON;
            cnt   <= CNT_ONE;
          end
        end

        S_CHK_ON: begin
          if (!btn) begin
            // Glitch: drop the count silently.
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_ON;
            cnt   <= '0;
            out   <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_ON: begin
          if (!btn) begin
            state <= S_CHK_OFF;
            cnt   <= CNT_ONE;
          end
        end

        S_CHK_OFF: begin
          if (btn) begin
            // Bounce while held: still pressed, no release.
            state <= S_ON;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            out           <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          out   <= 1'b0;
        end
      endcase
    end
  end

`ifdef LONG_PRESS_EN
  // -------------------------------------------------------------------------
  // Long-press hold timer
  // -------------------------------------------------------------------------
  // The timer counts every cycle spent pressed (S_ON and S_CHK_OFF). It is
  // 0 at the edge that enters S_ON, so at that edge + k it holds k. When it
  // holds LONG_CYCLES-1, the next edge raises long_press and parks the
  // counter at LONG_CYCLES. That value is never counted past, which gives
  // exactly one pulse per press even across rejected release bounces.
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] HOLD_SAT  = LW'(LONG_CYCLES);

  logic [LW-1:0] hold_cnt;

  // Count held cycles and fire long_press once at the threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt   <= '0;
      long_press <= 1'b0;
    end else begin
      long_press <= 1'b0;
      if (state == S_ON || state == S_CHK_OFF) begin
        if (hold_cnt == HOLD_LAST) begin
          hold_cnt   <= HOLD_SAT;
          long_press <= 1'b1;
        end else if (hold_cnt < HOLD_LAST) begin
          hold_cnt <= hold_cnt + LW'(1);
        end
      end else begin
        // Released or still qualifying a press: the next S_ON entry
        // starts from zero.
        hold_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Scoreboard bench for button_debounce, with DB_CYCLES=4, LONG_CYCLES=16,
// ACTIVE_LOW=1 and a 20 ns clock. Stimulus tasks push the expected pulses
// into a queue as {kind, posedge number}. A monitor runs on every falling
// edge. It pops the events due at the current posedge count and compares
// press, release_pulse, long_press and the modelled 'out' level against
// the DUT. Build with LONG_PRESS_EN defined to include long_press.
// ---------------------------------------------------------------------------
module tb_button_debounce;

  localparam int unsigned DB = 4;
  localparam int unsigned LC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b1;
  logic out;
  logic press;
  logic release_pulse;
`ifdef LONG_PRESS_EN
  logic long_press;
`endif

  button_debounce #(
    .DB_CYCLES  (DB),
    .ACTIVE_LOW (1'b1),
    .LONG_CYCLES(LC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .out          (out),
    .press        (press),
    .release_pulse(release_pulse)
`ifdef LONG_PRESS_EN
    ,
    .long_press   (long_press)
`endif
  );

  always #10 clk = ~clk;

  // Number of rising edges seen so far. At a falling edge, the next rising
  // edge is edge_cnt+1.
  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int unsigned edge_no;
  } ev_t;

  ev_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  logic exp_out = 1'b0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d",
               name, edge_cnt, actual, expected);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input int unsigned e);
    ev_t ev;
    ev.kind    = k;
    ev.edge_no = e;
    sb.push_back(ev);
  endtask

  // Drive the pin to v for n rising edges. Call at a falling edge; returns
  // at a falling edge.
  task automatic hold(input logic v, input int n);
    in = v;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: retire the events due now and compare every output.
  always @(negedge clk) begin : monitor
    ev_t  ev;
    logic ep;
    logic er;
    logic el;
    ep = 1'b0;
    er = 1'b0;
    el = 1'b0;
    while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
      ev = sb.pop_front();
      if (ev.edge_no != edge_cnt)
        check("stale event edge", edge_cnt, ev.edge_no);
      case (ev.kind)
        EV_PRESS:   begin ep = 1'b1; exp_out = 1'b1; end
        EV_RELEASE: begin er = 1'b1; exp_out = 1'b0; end
        default:    el = 1'b1;
      endcase
    end
    check("press", press, ep);
    check("release", release_pulse, er);
    check("out", out, exp_out);
`ifdef LONG_PRESS_EN
    check("long_press", long_press, el);
`endif
  end

  int unsigned n;

  initial begin
    // 1: reset held for 3 cycles, pin idle; the monitor expects all zeros.
    rst = 1'b1;
    in  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 2: clean press and release; each edge shows up 5 edges after it is
    //    first sampled.
    n = edge_cnt + 1;
    expect_ev(EV_PRESS, n + 5);
    hold(1'b0, 10);
    n = edge_cnt + 1;
    expect_ev(EV_RELEASE, n + 5);
    hold(1'b1, 10);

    // 3: bounce never reaches 4 stable samples, then a clean hold is
    //    accepted 5 edges after its first sample.
    hold(1'b0, 3);
    hold(1'b1, 1);
    hold(1'b0, 2);
    hold(1'b1, 8);
    n = edge_cnt + 1;
    expect_ev(EV_PRESS, n + 5);
    hold(1'b0, 10);
    n = edge_cnt + 1;
    expect_ev(EV_RELEASE, n + 5);
    hold(1'b1, 10);

    // 4: reset at edge n+3 discards the count; the press is debounced again
    //    and appears at n+4+5.
    n = edge_cnt + 1;
    expect_ev(EV_PRESS, n + 9);
    in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n = edge_cnt + 1;
    expect_ev(EV_RELEASE, n + 5);
    hold(1'b1, 10);

    // 5/6: long hold with a 2-cycle bounce after the long press. There is
    //      one press, one long_press 16 edges after the press, and no
    //      release until the pin really goes idle.
    n = edge_cnt + 1;
    expect_ev(EV_PRESS, n + 5);
`ifdef LONG_PRESS_EN
    expect_ev(EV_LONG, n + 5 + LC);
`endif
    hold(1'b0, 25);
    hold(1'b1, 2);
    hold(1'b0, 15);
    n = edge_cnt + 1;
    expect_ev(EV_RELEASE, n + 5);
    hold(1'b1, 12);

    repeat (5) @(negedge clk);
    check("scoreboard drained", sb.size(), 0);
    check("final out", out, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
